// File: rtl/hub75_rx_if.sv
// ---------------------------------------------------------------------------
// hub75_rx_if -- pixel stream produced by hub75_rx.
//
// One captured HUB75 row leaves the receiver as a valid/ready stream of
// 6-bit pixels tagged with their column index and the row address that was
// latched with the row.
//
// Signals
//   pix_valid  master->slave  pixel available
//   pix_ready  slave->master  consumer accepts the pixel this cycle
//   pix_data   master->slave  {b[1],g[1],r[1],b[0],g[0],r[0]}
//   pix_col    master->slave  column index, clog2(MATRIX_WIDTH) bits
//   pix_row    master->slave  row address latched with the row
//   row_done   master->slave  pulses in the cycle the last column is accepted
//
// Modports
//   master : used by hub75_rx
//   slave  : used by the pixel consumer
// ---------------------------------------------------------------------------
interface hub75_rx_if #(
    parameter int MATRIX_WIDTH = 64,
    parameter int ADDR_W       = 5
);
    localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;

    logic                pix_valid;
    logic                pix_ready;
    logic [5:0]          pix_data;
    logic [COL_W-1:0]    pix_col;
    logic [ADDR_W-1:0]   pix_row;
    logic                row_done;

    modport master (
        output pix_valid,
        output pix_data,
        output pix_col,
        output pix_row,
        output row_done,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_data,
        input  pix_col,
        input  pix_row,
        input  row_done,
        output pix_ready
    );
endinterface

// File: rtl/hub75_rx.sv
// ---------------------------------------------------------------------------
// hub75_rx -- HUB75 LED-panel bus receiver.
//
// Snoops a HUB75 bus (as driven by a panel controller) and turns each latched
// row into a valid/ready stream of 6-bit pixels. All HUB75 inputs are
// asynchronous to clk and pass through a SYNC_STAGES-deep synchronizer; clk
// must run at least 4x faster than led_clk so that every edge is seen.
//
// Data path
//   led_clk rising  -> shift event: pixel written to capture column k
//   latch rising    -> commit event: capture buffer (+ row address) copied
//                      into the hold buffer if the readout side is idle,
//                      otherwise the row is dropped and ovr_err is set
//   hold buffer     -> streamed out on the pix interface, column 0 first
//
// Parameters
//   MATRIX_WIDTH  columns per row            (default 64)
//   ADDR_W        row address width          (default 5)
//   SYNC_STAGES   synchronizer depth, >= 2   (default 2)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   r, g, b               HUB75 colour pairs {lower, upper}
//   addr                  HUB75 row address
//   latch                 HUB75 latch, active-high
//   blank                 HUB75 output enable, active-low
//   led_clk               HUB75 shift clock
//   err_clr               synchronous clear of the sticky error flags
//   len_err               sticky: column count mismatch at commit / overflow
//   ovr_err               sticky: row dropped, hold buffer busy
//   proto_err             sticky: blank protocol violation
//   pix                   hub75_rx_if.master pixel stream
//
// Build option
//   HUB75_RX_BLANK_CHECK_EN  when defined, blank is synchronized and checked:
//                            a shift while blank=1 or a commit while blank=0
//                            sets proto_err. When undefined, blank is ignored
//                            and proto_err is tied low.
// ---------------------------------------------------------------------------
module hub75_rx #(
    parameter int MATRIX_WIDTH = 64,
    parameter int ADDR_W       = 5,
    parameter int SYNC_STAGES  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        r,
    input  logic [1:0]        g,
    input  logic [1:0]        b,
    input  logic [ADDR_W-1:0] addr,
    input  logic              latch,
    input  logic              blank,
    input  logic              led_clk,
    input  logic              err_clr,
    output logic              len_err,
    output logic              ovr_err,
    output logic              proto_err,
    hub75_rx_if.master        pix
);

    localparam int COL_W = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
    // The column counter needs one extra bit so it can hold MATRIX_WIDTH
    // itself (a complete row) and saturate there.
    localparam int CNT_W = COL_W + 1;
    localparam int IN_W  = 8 + ADDR_W;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MATRIX_WIDTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MATRIX_WIDTH - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_SEND  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronizers
    // -----------------------------------------------------------------------
    logic [IN_W-1:0]                   w_sync_in;
    logic [SYNC_STAGES-1:0][IN_W-1:0]  r_sync;
    logic [IN_W-1:0]                   w_sync_out;

    assign w_sync_in = {led_clk, latch, addr, b, g, r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_sync_in};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    logic [1:0]        w_r_s;
    logic [1:0]        w_g_s;
    logic [1:0]        w_b_s;
    logic [ADDR_W-1:0] w_addr_s;
    logic              w_latch_s;
    logic              w_led_clk_s;
    logic [5:0]        w_pix;

    assign w_r_s       = w_sync_out[1:0];
    assign w_g_s       = w_sync_out[3:2];
    assign w_b_s       = w_sync_out[5:4];
    assign w_addr_s    = w_sync_out[6 +: ADDR_W];
    assign w_latch_s   = w_sync_out[6 + ADDR_W];
    assign w_led_clk_s = w_sync_out[7 + ADDR_W];
    assign w_pix       = {w_b_s[1], w_g_s[1], w_r_s[1], w_b_s[0], w_g_s[0], w_r_s[0]};

    // -----------------------------------------------------------------------
    // Edge detection on the synchronized strobes
    // -----------------------------------------------------------------------
    logic r_led_clk_prev;
    logic r_latch_prev;
    logic w_shift;
    logic w_commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led_clk_prev <= 1'b0;
            r_latch_prev   <= 1'b0;
        end else begin
            r_led_clk_prev <= w_led_clk_s;
            r_latch_prev   <= w_latch_s;
        end
    end

    assign w_shift  = w_led_clk_s & ~r_led_clk_prev;
    assign w_commit = w_latch_s & ~r_latch_prev;

    // -----------------------------------------------------------------------
    // Capture buffer
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]                  r_cnt;
    logic                              w_room;
    logic                              w_wr;
    logic [CNT_W-1:0]                  w_cnt_eff;
    logic [MATRIX_WIDTH-1:0][5:0]      r_cap;
    logic [MATRIX_WIDTH-1:0]           r_cap_vld;
    logic [MATRIX_WIDTH-1:0]           w_hit;
    logic [MATRIX_WIDTH-1:0][5:0]      w_eff;

    assign w_room    = (r_cnt < CNT_FULL);
    assign w_wr      = w_shift & w_room;
    // Count as seen by a same-cycle commit: the shift lands in the row first.
    assign w_cnt_eff = r_cnt + CNT_W'(w_wr);

    // w_eff is the row image a commit would transfer this cycle: the current
    // shift (if any) merged in, and columns not written since the previous
    // commit forced to zero via the per-column valid bits.
    generate
        for (genvar gi = 0; gi < MATRIX_WIDTH; gi++) begin : g_col
            assign w_hit[gi] = w_wr && (r_cnt == CNT_W'(gi));
            assign w_eff[gi] = w_hit[gi]     ? w_pix     :
                               r_cap_vld[gi] ? r_cap[gi] : 6'd0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_commit) begin
            r_cnt <= '0;
        end else if (w_wr) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_vld <= '0;
        end else if (w_commit) begin
            r_cap_vld <= '0;
        end else begin
            r_cap_vld <= r_cap_vld | w_hit;
        end
    end

    // Pixel storage needs no reset: the valid bits gate every read.
    always_ff @(posedge clk) begin
        for (int k = 0; k < MATRIX_WIDTH; k++) begin
            if (w_hit[k]) begin
                r_cap[k] <= w_pix;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Readout FSM
    // -----------------------------------------------------------------------
    state_t r_state;
    state_t w_state_next;
    logic   w_xfer;
    logic   w_drop;
    logic   w_valid;
    logic   w_accept;
    logic   w_last;

    logic [MATRIX_WIDTH-1:0][5:0] r_hold;
    logic [5:0]                   r_pix_data;
    logic [COL_W-1:0]             r_pix_col;
    logic [ADDR_W-1:0]            r_pix_row;
    logic [COL_W-1:0]             w_col_inc;

    assign w_valid   = (r_state == ST_SEND);
    assign w_accept  = w_valid & pix.pix_ready;
    assign w_last    = (r_pix_col == COL_LAST);
    assign w_col_inc = r_pix_col + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_xfer       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_xfer = w_commit;
                if (w_commit) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // A commit while a row is still streaming loses that row.
                w_drop = w_commit;
                if (w_accept && w_last) begin
                    w_state_next = ST_EMPTY;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_hold <= w_eff;
        end
    end

    // Output registers only move on transfer or acceptance, so they hold
    // steady through any stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_data <= '0;
            r_pix_col  <= '0;
            r_pix_row  <= '0;
        end else if (w_xfer) begin
            r_pix_data <= w_eff[0];
            r_pix_col  <= '0;
            r_pix_row  <= w_addr_s;
        end else if (w_accept && !w_last) begin
            r_pix_data <= r_hold[w_col_inc];
            r_pix_col  <= w_col_inc;
        end
    end

    assign pix.pix_valid = w_valid;
    assign pix.pix_data  = r_pix_data;
    assign pix.pix_col   = r_pix_col;
    assign pix.pix_row   = r_pix_row;
    assign pix.row_done  = w_accept & w_last;

    // -----------------------------------------------------------------------
    // Sticky error flags (a set in the same cycle as err_clr wins)
    // -----------------------------------------------------------------------
    logic r_len_err;
    logic r_ovr_err;
    logic w_len_set;

    assign w_len_set = (w_shift && !w_room) ||
                       (w_commit && (w_cnt_eff != CNT_FULL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len_err <= 1'b0;
            r_ovr_err <= 1'b0;
        end else begin
            r_len_err <= w_len_set | (r_len_err & ~err_clr);
            r_ovr_err <= w_drop    | (r_ovr_err & ~err_clr);
        end
    end

    assign len_err = r_len_err;
    assign ovr_err = r_ovr_err;

`ifdef HUB75_RX_BLANK_CHECK_EN
    // blank idles high (display off) so its synchronizer resets to 1.
    logic [SYNC_STAGES-1:0] r_blank_sync;
    logic                   w_blank_s;
    logic                   w_proto_set;
    logic                   r_proto_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blank_sync <= '1;
        end else begin
            r_blank_sync <= {r_blank_sync[SYNC_STAGES-2:0], blank};
        end
    end

    assign w_blank_s   = r_blank_sync[SYNC_STAGES-1];
    assign w_proto_set = (w_shift && w_blank_s) || (w_commit && !w_blank_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= w_proto_set | (r_proto_err & ~err_clr);
        end
    end

    assign proto_err = r_proto_err;
`else
    logic w_unused_blank;

    assign w_unused_blank = blank;
    assign proto_err      = 1'b0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
module tb_hub75_rx;

    localparam int W  = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    r;
    logic [1:0]    g;
    logic [1:0]    b;
    logic [AW-1:0] addr;
    logic          latch;
    logic          blank;
    logic          led_clk;
    logic          err_clr;
    logic          len_err;
    logic          ovr_err;
    logic          proto_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hub75_rx_if #(.MATRIX_WIDTH(W), .ADDR_W(AW)) pix_if ();

    hub75_rx #(
        .MATRIX_WIDTH (W),
        .ADDR_W       (AW),
        .SYNC_STAGES  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r         (r),
        .g         (g),
        .b         (b),
        .addr      (addr),
        .latch     (latch),
        .blank     (blank),
        .led_clk   (led_clk),
        .err_clr   (err_clr),
        .len_err   (len_err),
        .ovr_err   (ovr_err),
        .proto_err (proto_err),
        .pix       (pix_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One led_clk period of four clk cycles, data set up with the low phase.
    task automatic shift_px(input logic [1:0] rr, input logic [1:0] gg, input logic [1:0] bb);
        r = rr; g = gg; b = bb;
        led_clk = 1'b0;
        cycles(2);
        led_clk = 1'b1;
        cycles(2);
    endtask

    task automatic shift_row(input int n, input logic [1:0] rr, input logic [1:0] gg, input logic [1:0] bb);
        for (int i = 0; i < n; i++) shift_px(rr, gg, bb);
    endtask

    task automatic do_latch(input logic [AW-1:0] a);
        addr  = a;
        blank = 1'b1;
        cycles(2);
        latch = 1'b1;
        cycles(2);
        latch = 1'b0;
        cycles(2);
        blank = 1'b0;
        cycles(2);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        cycles(1);
    endtask

    task automatic check_flags(input string tag, input logic le, input logic oe, input logic pe);
        check({tag, ".len_err"},   len_err,   le);
        check({tag, ".ovr_err"},   ovr_err,   oe);
        check({tag, ".proto_err"}, proto_err, pe);
    endtask

    // Drains one row. Every cycle with pix_valid the current column, data,
    // row tag and row_done are compared; while stalled the column must not
    // advance, so a stall that corrupts outputs shows up as a miscompare.
    task automatic read_row(input string tag, input logic [5:0] pat, input int nfill,
                            input logic [AW-1:0] row, input bit toggle);
        int acc   = 0;
        int dones = 0;
        for (int cyc = 0; cyc < 500 && acc < W; cyc++) begin
            @(negedge clk);
            pix_if.pix_ready = toggle ? cyc[0] : 1'b1;
            #1;
            if (pix_if.pix_valid) begin
                check({tag, ".col"},  pix_if.pix_col,  acc);
                check({tag, ".data"}, pix_if.pix_data, (acc < nfill) ? pat : 6'd0);
                check({tag, ".row"},  pix_if.pix_row,  row);
                check({tag, ".row_done"}, pix_if.row_done, pix_if.pix_ready && (acc == W - 1));
                if (pix_if.pix_ready) begin
                    if (pix_if.row_done) dones++;
                    acc++;
                end
            end
        end
        @(negedge clk);
        pix_if.pix_ready = 1'b0;
        check({tag, ".accepts"},      acc,              W);
        check({tag, ".row_done_cnt"}, dones,            1);
        check({tag, ".valid_after"},  pix_if.pix_valid, 1'b0);
        $display("row %s: %0d pixels accepted, row_done x%0d", tag, acc, dones);
    endtask

    initial begin
        int found;
        int valids;

        rst_n   = 1'b0;
        r       = '0;
        g       = '0;
        b       = '0;
        addr    = '0;
        latch   = 1'b0;
        blank   = 1'b0;
        led_clk = 1'b0;
        err_clr = 1'b0;
        pix_if.pix_ready = 1'b0;

        // Reset state
        cycles(3);
        check("rst.valid",    pix_if.pix_valid, 1'b0);
        check("rst.col",      pix_if.pix_col,   0);
        check("rst.row",      pix_if.pix_row,   0);
        check("rst.data",     pix_if.pix_data,  0);
        check("rst.row_done", pix_if.row_done,  1'b0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycles(2);
        $display("reset released");

        // Full row: r=01 b=10 -> 6'b100001, row 3
        shift_row(64, 2'b01, 2'b00, 2'b10);
        do_latch(5'd3);
        check_flags("s1.latch", 1'b0, 1'b0, 1'b0);
        read_row("s1", 6'b100001, 64, 5'd3, 1'b0);
        check_flags("s1.end", 1'b0, 1'b0, 1'b0);

        // Short row: 60 columns, tail reads zero
        shift_row(60, 2'b11, 2'b01, 2'b00);
        do_latch(5'd7);
        check_flags("s2.latch", 1'b1, 1'b0, 1'b0);
        read_row("s2", 6'b001011, 60, 5'd7, 1'b0);
        clear_errs();
        check("s2.len_clr", len_err, 1'b0);

        // Overrun: second latch while the first row is stalled
        shift_row(64, 2'b10, 2'b10, 2'b01);
        do_latch(5'd9);
        check("s3.stall_valid", pix_if.pix_valid, 1'b1);
        check("s3.stall_col",   pix_if.pix_col,   0);
        check("s3.stall_data",  pix_if.pix_data,  6'b011100);
        shift_row(64, 2'b11, 2'b11, 2'b11);
        do_latch(5'd2);
        check_flags("s3.latch2", 1'b0, 1'b1, 1'b0);
        check("s3.hold_row",  pix_if.pix_row,  5'd9);
        check("s3.hold_data", pix_if.pix_data, 6'b011100);
        read_row("s3", 6'b011100, 64, 5'd9, 1'b0);
        valids = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pix_if.pix_valid) valids++;
        end
        check("s3.dropped_row_silent", valids, 0);
        clear_errs();
        check("s3.ovr_clr", ovr_err, 1'b0);

        // Back-pressure every other cycle
        shift_row(64, 2'b00, 2'b11, 2'b00);
        do_latch(5'd31);
        read_row("s4", 6'b010010, 64, 5'd31, 1'b1);
        check_flags("s4.end", 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a readout
        shift_row(63, 2'b01, 2'b01, 2'b01);
        do_latch(5'd4);
        check("s5.len_before", len_err, 1'b1);
        led_clk = 1'b0;
        pix_if.pix_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (pix_if.pix_valid && pix_if.pix_col == 6'd30) begin
                found = 1;
                break;
            end
        end
        check("s5.reach_col30", found, 1);
        rst_n = 1'b0;
        #1;
        check("s5.rst_valid", pix_if.pix_valid, 1'b0);
        check("s5.rst_col",   pix_if.pix_col,   0);
        check("s5.rst_row",   pix_if.pix_row,   0);
        check_flags("s5.rst", 1'b0, 1'b0, 1'b0);
        cycles(2);
        rst_n = 1'b1;
        valids = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_if.pix_valid) valids++;
        end
        check("s5.no_output_after_rst", valids, 0);
        pix_if.pix_ready = 1'b0;
        do_latch(5'd1);
        check("s5.len_empty_row", len_err, 1'b1);
        read_row("s5", 6'b000000, 0, 5'd1, 1'b0);
        clear_errs();

        // Shift while blank is high
        blank = 1'b1;
        shift_px(2'b01, 2'b00, 2'b00);
        blank = 1'b0;
        cycles(2);
`ifdef HUB75_RX_BLANK_CHECK_EN
        check("s6.proto_set", proto_err, 1'b1);
        clear_errs();
        check("s6.proto_clr", proto_err, 1'b0);
`else
        check("s6.proto_tied", proto_err, 1'b0);
`endif
        $display("blank check step done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hub75_rx.md
HUB75_RX -- requirements
Module: hub75_rx

Interface
REQ-001 The block SHALL have parameters, one per line: name, default, meaning.
- MATRIX_WIDTH, 64, columns per row.
- ADDR_W, 5, row address width.
- SYNC_STAGES, 2, synchronizer depth on all HUB75 inputs (minimum 2).

REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; rising-edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- r, in, 2, HUB75 red, upper/lower half.
- g, in, 2, HUB75 green.
- b, in, 2, HUB75 blue.
- addr, in, ADDR_W, HUB75 row address.
- latch, in, 1, HUB75 latch; active-high.
- blank, in, 1, HUB75 output enable; active-low.
- led_clk, in, 1, HUB75 shift clock.
- pix_valid, out, 1, pixel available.
- pix_ready, in, 1, consumer accepts pixel.
- pix_data, out, 6, {b[1],g[1],r[1],b[0],g[0],r[0]}.
- pix_col, out, clog2(MATRIX_WIDTH), column index.
- pix_row, out, ADDR_W, row address latched with the row.
- row_done, out, 1, one-cycle pulse on acceptance of the last pixel of a row.
- len_err, out, 1, sticky flag: column count mismatch.
- ovr_err, out, 1, sticky flag: row dropped because the hold buffer was busy.
- proto_err, out, 1, sticky flag: protocol violation (see Configuration).
- err_clr, in, 1, synchronous clear of all sticky flags.

Function
REQ-003 The block SHALL pass every HUB75 input through SYNC_STAGES flops before use; clk SHALL run at no less than 4x the led_clk frequency.
REQ-004 The block SHALL treat a synchronized 0->1 transition of led_clk as a shift event and sample the synchronized r/g/b on that same cycle.
REQ-005 The k-th shift event after the last commit (k from 0) SHALL store its 6-bit pixel in capture-buffer column k; events with k >= MATRIX_WIDTH SHALL be discarded and SHALL set len_err.
REQ-006 The block SHALL treat a synchronized 0->1 transition of latch as a commit event. On a commit event the block SHALL:
- sample addr into the row tag;
- reset the column count to 0;
- set len_err if the count is not equal to MATRIX_WIDTH.
REQ-007 If the readout FSM is EMPTY at a commit, the capture buffer and row tag SHALL transfer to the hold buffer in that cycle; columns not written since the last commit SHALL read as 0.
REQ-008 If the readout FSM is SEND at a commit, the row SHALL be dropped, ovr_err SHALL be set, and the hold contents SHALL be unchanged.
REQ-009 The readout FSM SHALL have two states, EMPTY and SEND:
- EMPTY->SEND on commit;
- SEND->EMPTY when column MATRIX_WIDTH-1 is accepted.
REQ-010 pix_valid SHALL assert on the cycle after the transfer and remain high in SEND; pix_col SHALL start at 0 and advance by 1 per cycle with pix_valid&&pix_ready.
REQ-011 pix_data, pix_col and pix_row SHALL be stable while pix_valid&&!pix_ready.
REQ-012 row_done SHALL pulse in the cycle the last column is accepted.
REQ-013 A shift event and a commit in the same cycle SHALL apply the shift to the committed row first, then commit.
REQ-014 err_clr SHALL clear the flags; a set condition in the same cycle as err_clr SHALL win.

Reset
REQ-015 rst_n low SHALL asynchronously force:
- all synchronizer flops to 0, except blank to 1;
- column count 0;
- FSM EMPTY;
- pix_valid 0, pix_col 0, pix_row 0, pix_data 0, row_done 0;
- all error flags 0.
REQ-016 Reset asserted mid-row or mid-readout SHALL discard all buffered pixels; no pix_valid SHALL occur until a new commit after release.

Configuration
REQ-017 With HUB75_RX_BLANK_CHECK_EN defined, proto_err SHALL set when:
- a shift event occurs while synchronized blank=1; or
- a commit occurs while blank=0.
REQ-018 Without HUB75_RX_BLANK_CHECK_EN, proto_err SHALL be tied to 0 and blank SHALL be unused.

Verification
REQ-019 The bench SHALL cover the following scenarios:
- 64 shifts with r=2'b01,b=2'b10 at addr=3, then latch, pix_ready=1 -> 64 pixels, pix_data=6'b100001, pix_row=3, pix_col 0..63, row_done once, no errors.
- 60 shifts then latch -> len_err=1; columns 60..63 read 0.
- Second latch while the first row is stalled with pix_ready=0 -> ovr_err=1; the first row's data is delivered intact.
- pix_ready toggled every cycle -> outputs held while stalled; 64 accepts total.
- rst_n pulsed low at column 30 of readout -> pix_valid=0 immediately, flags 0, no output until the next latch.
- HUB75_RX_BLANK_CHECK_EN defined, shift with blank=1 -> proto_err=1; err_clr -> 0.
